// File: rtl/triangle_vertex_assembler_pkg.sv
// ----------------------------------------------------------------------------
// tri_pkg
// Shared definitions for the triangle vertex assembler slice.
//   XW, YW     : screen coordinate widths (x 0..2047, y 0..1023)
//   vertex_t   : one screen vertex {x, y}, no sign, no arithmetic applied
//   vcnt_e     : how far the current primitive has progressed
//                VCNT_0/1/2 = vertices collected towards a list-style triangle,
//                VCNT_STRIP = strip primed, every further vertex closes a triangle
// ----------------------------------------------------------------------------
package tri_pkg;

    localparam int XW = 11;
    localparam int YW = 10;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } vertex_t;

    typedef enum logic [1:0] {
        VCNT_0     = 2'd0,
        VCNT_1     = 2'd1,
        VCNT_2     = 2'd2,
        VCNT_STRIP = 2'd3
    } vcnt_e;

endpackage

// File: rtl/triangle_vertex_assembler_if.sv
// ----------------------------------------------------------------------------
// triangle_vertex_assembler_if
// Vertex stream feeding the assembler (valid/ready handshake).
//   in_valid   : vertex on vx/vy/in_last is valid
//   in_ready   : assembler takes the vertex this cycle
//   vx, vy     : vertex coordinates
//   in_last    : vertex closes the current primitive
//   strip_mode : 0 = triangle list, 1 = triangle strip (used at primitive start)
// Modports: master = vertex producer, slave = assembler.
// ----------------------------------------------------------------------------
interface triangle_vertex_assembler_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [tri_pkg::XW-1:0]   vx;
    logic [tri_pkg::YW-1:0]   vy;
    logic                     in_last;
    logic                     strip_mode;

    modport master (
        output in_valid, vx, vy, in_last, strip_mode,
        input  in_ready
    );

    modport slave (
        input  in_valid, vx, vy, in_last, strip_mode,
        output in_ready
    );

endinterface

// File: rtl/triangle_vertex_assembler.sv
// ----------------------------------------------------------------------------
// triangle_vertex_assembler
// Collects screen vertices into triangles (list or strip) for the area stage.
// Strip triangles alternate a/b so the winding, and thus the sign of the
// downstream signed area, stays the same along a whole strip.
// Ports:
//   CLOCK_50   : clock, all state on the rising edge
//   RESET_N    : asynchronous active-low reset
//   vin        : vertex stream (slave side of triangle_vertex_assembler_if)
//   tri_valid  : ax..cy hold a complete triangle
//   tri_ready  : area stage takes the triangle this cycle
//   ax..cy     : registered triangle vertices
//   tri_count  : triangles handed downstream, wraps at 2^CNTW
//   drop_err   : sticky, a primitive ended before it had three vertices
// ----------------------------------------------------------------------------
module triangle_vertex_assembler
    import tri_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET_N,
    triangle_vertex_assembler_if.slave  vin,
    output logic                        tri_valid,
    input  logic                        tri_ready,
    output logic [XW-1:0]               ax,
    output logic [YW-1:0]               ay,
    output logic [XW-1:0]               bx,
    output logic [YW-1:0]               by,
    output logic [XW-1:0]               cx,
    output logic [YW-1:0]               cy,
    output logic [CNTW-1:0]             tri_count,
    output logic                        drop_err
);

    vcnt_e           vcnt_q, vcnt_d;
    logic            odd_q, odd_d;
    logic            mode_q, mode_d;
    vertex_t         h0_q, h1_q;
    vertex_t         a_q, b_q, c_q;
    vertex_t         a_d, b_d;
    vertex_t         vin_v;
    logic            valid_q;
    logic [CNTW-1:0] count_q;
    logic            drop_q;
    logic            completes;
    logic            rdy;
    logic            accept;
    logic            emit;
    logic            load;
    logic            drop_set;

    // A completing vertex needs the output register, so it may only be taken
    // when that register is empty or being drained in this same cycle.
    assign vin_v        = vertex_t'{x: vin.vx, y: vin.vy};
    assign completes    = (vcnt_q == VCNT_2) || (vcnt_q == VCNT_STRIP);
    assign rdy          = !completes || !valid_q || tri_ready;
    assign vin.in_ready = rdy;
    assign accept       = vin.in_valid && rdy;
    assign emit         = valid_q && tri_ready;

    // Primitive progress register: vertex count, strip parity and the
    // topology latched when the primitive started.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            vcnt_q <= VCNT_0;
            odd_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            vcnt_q <= vcnt_d;
            odd_q  <= odd_d;
            mode_q <= mode_d;
        end
    end

    // Next-state decode. The second strip triangle onwards reuses the two
    // history vertices; odd triangles swap a/b to keep one winding. An in_last
    // vertex is still used normally and then the primitive restarts; if the
    // primitive never reached a triangle it is dropped and flagged.
    always_comb begin
        vcnt_d   = vcnt_q;
        odd_d    = odd_q;
        mode_d   = mode_q;
        load     = 1'b0;
        drop_set = 1'b0;
        a_d      = h0_q;
        b_d      = h1_q;
        if (accept) begin
            unique case (vcnt_q)
                VCNT_0: begin
                    mode_d = vin.strip_mode;
                    odd_d  = 1'b0;
                    vcnt_d = VCNT_1;
                end
                VCNT_1: begin
                    vcnt_d = VCNT_2;
                end
                VCNT_2: begin
                    load   = 1'b1;
                    odd_d  = mode_q;
                    vcnt_d = mode_q ? VCNT_STRIP : VCNT_0;
                end
                VCNT_STRIP: begin
                    load  = 1'b1;
                    odd_d = !odd_q;
                    if (odd_q) begin
                        a_d = h1_q;
                        b_d = h0_q;
                    end
                end
            endcase
            if (vin.in_last) begin
                vcnt_d   = VCNT_0;
                odd_d    = 1'b0;
                drop_set = !completes;
            end
        end
    end

    // Vertex history, triangle output register and status. A load in the
    // same cycle as an emit simply replaces the triangle and keeps valid high.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            h0_q    <= '0;
            h1_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (accept) begin
                h0_q <= h1_q;
                h1_q <= vin_v;
            end
            if (load) begin
                a_q     <= a_d;
                b_q     <= b_d;
                c_q     <= vin_v;
                valid_q <= 1'b1;
            end else if (emit) begin
                valid_q <= 1'b0;
            end
            if (emit) begin
                count_q <= count_q + CNTW'(1);
            end
            if (drop_set) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign tri_valid = valid_q;
    assign ax        = a_q.x;
    assign ay        = a_q.y;
    assign bx        = b_q.x;
    assign by        = b_q.y;
    assign cx        = c_q.x;
    assign cy        = c_q.y;
    assign tri_count = count_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_triangle_vertex_assembler.sv
// ----------------------------------------------------------------------------
// tb_triangle_vertex_assembler
// Directed scenarios (list, backpressure, strip, restart, reset, wrap) followed
// by randomized traffic. A queue-based model of primitives tracks the expected
// triangle, counter and error flag; a negedge process compares every cycle.
// ----------------------------------------------------------------------------
module tb_triangle_vertex_assembler;

    localparam int CNTW_TB = 4;

    logic                 CLOCK_50 = 1'b0;
    logic                 RESET_N  = 1'b0;
    logic                 tri_ready = 1'b0;
    logic                 tri_valid;
    logic [10:0]          ax, bx, cx;
    logic [9:0]           ay, by, cy;
    logic [CNTW_TB-1:0]   tri_count;
    logic                 drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int px[$];
    int py[$];
    bit m_mode     = 1'b0;
    bit m_valid    = 1'b0;
    bit m_drop     = 1'b0;
    bit m_accepted = 1'b0;
    int m_count    = 0;
    int e_ax = 0, e_ay = 0, e_bx = 0, e_by = 0, e_cx = 0, e_cy = 0;
    bit acc, emt;
    int n;

    triangle_vertex_assembler_if vif();

    triangle_vertex_assembler #(.CNTW(CNTW_TB)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .vin       (vif),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .cx        (cx),
        .cy        (cy),
        .tri_count (tri_count),
        .drop_err  (drop_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // A vertex closes a triangle once two vertices of the primitive are held.
    function automatic bit model_in_ready();
        bit comp;
        comp = m_mode ? (px.size() >= 2) : (px.size() == 2);
        return !comp || !m_valid || tri_ready;
    endfunction

    // Behavioural model: primitives as vertex queues, triangles picked by index.
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            px.delete();
            py.delete();
            m_mode = 1'b0;
            m_valid = 1'b0;
            m_drop = 1'b0;
            m_count = 0;
            m_accepted = 1'b0;
            e_ax = 0; e_ay = 0; e_bx = 0; e_by = 0; e_cx = 0; e_cy = 0;
        end else begin
            acc = vif.in_valid && model_in_ready();
            emt = m_valid && tri_ready;
            if (emt) begin
                m_count = (m_count + 1) % (1 << CNTW_TB);
                m_valid = 1'b0;
            end
            if (acc) begin
                n = px.size();
                if (n == 0) m_mode = vif.strip_mode;
                if (n >= 2) begin
                    if (m_mode && ((n - 2) % 2 == 1)) begin
                        e_ax = px[n-1]; e_ay = py[n-1];
                        e_bx = px[n-2]; e_by = py[n-2];
                    end else begin
                        e_ax = px[n-2]; e_ay = py[n-2];
                        e_bx = px[n-1]; e_by = py[n-1];
                    end
                    e_cx = int'(vif.vx);
                    e_cy = int'(vif.vy);
                    m_valid = 1'b1;
                end
                if (vif.in_last) begin
                    if (n < 2) m_drop = 1'b1;
                    px.delete();
                    py.delete();
                end else if (!m_mode && n == 2) begin
                    px.delete();
                    py.delete();
                end else begin
                    px.push_back(int'(vif.vx));
                    py.push_back(int'(vif.vy));
                end
            end
            m_accepted = acc;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLOCK_50) begin
        checkOutput("tri_valid", tri_valid, m_valid);
        checkOutput("in_ready", vif.in_ready, model_in_ready());
        checkOutput("tri_count", tri_count, m_count);
        checkOutput("drop_err", drop_err, m_drop);
        if (m_valid) begin
            checkOutput("ax", ax, e_ax);
            checkOutput("ay", ay, e_ay);
            checkOutput("bx", bx, e_bx);
            checkOutput("by", by, e_by);
            checkOutput("cx", cx, e_cx);
            checkOutput("cy", cy, e_cy);
        end
    end

    task automatic applyStimulus(input bit valid, input int x, input int y, input bit last, input bit mode);
        vif.in_valid   = valid;
        vif.vx         = 11'(x);
        vif.vy         = 10'(y);
        vif.in_last    = last;
        vif.strip_mode = mode;
    endtask

    task automatic sendVertex(input int x, input int y, input bit last, input bit mode);
        bit done;
        done = 1'b0;
        applyStimulus(1'b1, x, y, last, mode);
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge CLOCK_50);
            #1;
            done = m_accepted;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: vertex (%0d,%0d) not taken, required within 50 cycles", x, y);
        end
        vif.in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        vif.in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic pulseReset();
        RESET_N = 1'b0;
        #1;
        checkOutput("rst_tri_valid", tri_valid, 0);
        checkOutput("rst_ax", ax, 0);
        checkOutput("rst_cy", cy, 0);
        checkOutput("rst_tri_count", tri_count, 0);
        checkOutput("rst_drop_err", drop_err, 0);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic checkTri(input string name, input int a_x, input int a_y, input int b_x,
                            input int b_y, input int c_x, input int c_y);
        checkOutput({name, "_valid"}, tri_valid, 1);
        checkOutput({name, "_ax"}, ax, a_x);
        checkOutput({name, "_ay"}, ay, a_y);
        checkOutput({name, "_bx"}, bx, b_x);
        checkOutput({name, "_by"}, by, b_y);
        checkOutput({name, "_cx"}, cx, c_x);
        checkOutput({name, "_cy"}, cy, c_y);
    endtask

    initial begin
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        checkOutput("init_tri_valid", tri_valid, 0);
        checkOutput("init_tri_count", tri_count, 0);
        checkOutput("init_bx", bx, 0);
        RESET_N = 1'b1;

        // list triangle held by backpressure
        tri_ready = 1'b0;
        sendVertex(1, 82, 1'b0, 1'b0);
        sendVertex(47, 1, 1'b0, 1'b0);
        sendVertex(47, 165, 1'b0, 1'b0);
        checkTri("list", 1, 82, 47, 1, 47, 165);

        // two more accepted, the completing one stalls
        sendVertex(2, 3, 1'b0, 1'b0);
        sendVertex(4, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 6, 7, 1'b0, 1'b0);
        @(posedge CLOCK_50);
        #1;
        checkOutput("bp_in_ready", vif.in_ready, 0);
        checkTri("bp_hold", 1, 82, 47, 1, 47, 165);
        tri_ready = 1'b1;
        sendVertex(6, 7, 1'b0, 1'b0);
        checkTri("bp_reload", 2, 3, 4, 5, 6, 7);
        checkOutput("bp_count1", tri_count, 1);
        idle(1);
        checkOutput("bp_count2", tri_count, 2);

        // strip, back to back, winding swap on the second triangle
        sendVertex(1, 5, 1'b0, 1'b1);
        sendVertex(15, 25, 1'b0, 1'b1);
        sendVertex(3, 50, 1'b0, 1'b1);
        checkTri("strip_t0", 1, 5, 15, 25, 3, 50);
        sendVertex(20, 60, 1'b1, 1'b1);
        checkTri("strip_t1", 3, 50, 15, 25, 20, 60);
        idle(1);
        checkOutput("strip_count", tri_count, 4);
        checkOutput("strip_no_drop", drop_err, 0);

        // restart on the second vertex
        sendVertex(5, 5, 1'b0, 1'b0);
        sendVertex(6, 6, 1'b1, 1'b0);
        checkOutput("restart_drop", drop_err, 1);
        checkOutput("restart_no_tri", tri_valid, 0);
        sendVertex(7, 8, 1'b0, 1'b0);
        sendVertex(9, 10, 1'b0, 1'b0);
        sendVertex(11, 12, 1'b0, 1'b0);
        checkTri("restart_tri", 7, 8, 9, 10, 11, 12);
        idle(1);

        // reset mid-primitive
        sendVertex(100, 200, 1'b0, 1'b0);
        sendVertex(300, 400, 1'b0, 1'b0);
        pulseReset();
        sendVertex(500, 600, 1'b0, 1'b0);
        sendVertex(700, 800, 1'b0, 1'b0);
        checkOutput("post_rst_no_tri", tri_valid, 0);
        sendVertex(900, 1000, 1'b0, 1'b0);
        checkTri("post_rst_tri", 500, 600, 700, 800, 900, 1000);
        idle(1);

        // counter wrap: 17 triangles on a 4-bit counter
        pulseReset();
        for (int t = 0; t < 17; t++) begin
            for (int v = 0; v < 3; v++) begin
                sendVertex($urandom_range(0, 2047), $urandom_range(0, 1023), 1'b0, 1'b0);
            end
        end
        idle(2);
        checkOutput("wrap_count", tri_count, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!RESET_N) begin
                RESET_N = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                RESET_N = 1'b0;
            end
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2047), $urandom_range(0, 1023),
                          $urandom_range(0, 9) == 0,
                          ($urandom_range(0, 19) == 0) ? !vif.strip_mode : vif.strip_mode);
            tri_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLOCK_50);
            #1;
        end
        RESET_N = 1'b1;
        tri_ready = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
